// File: rtl/forward_controller_pkg.sv
// forward_controller_pkg: forward mux encodings and shadow pipeline entry type
package forward_controller_pkg;

    localparam int FWD_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } forward_mux_code;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [FWD_REG_W-1:0] rd;
        logic                 load;
    } fwd_shadow_t;

    localparam fwd_shadow_t FWD_BUBBLE = '0;

endpackage

// File: rtl/forward_controller_if.sv
// forward_controller_if: Decode-side request and EX-side forward/stall response bundle
interface forward_controller_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 32
);
    import forward_controller_pkg::*;

    logic                   id_valid_ip;
    logic [REG_ADDR_W-1:0]  id_rs1_addr_ip;
    logic [REG_ADDR_W-1:0]  id_rs2_addr_ip;
    logic                   id_rs1_used_ip;
    logic                   id_rs2_used_ip;
    logic [REG_ADDR_W-1:0]  id_rd_addr_ip;
    logic                   id_reg_write_ip;
    logic                   id_is_load_ip;
    logic                   flush_en_ip;
    forward_mux_code        fa_mux_op;
    forward_mux_code        fb_mux_op;
    logic                   stall_op;
    logic [STALL_CNT_W-1:0] stall_count_op;

    modport master (
        output id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip, id_rs2_used_ip,
               id_rd_addr_ip, id_reg_write_ip, id_is_load_ip, flush_en_ip,
        input  fa_mux_op, fb_mux_op, stall_op, stall_count_op
    );

    modport slave (
        input  id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip, id_rs2_used_ip,
               id_rd_addr_ip, id_reg_write_ip, id_is_load_ip, flush_en_ip,
        output fa_mux_op, fb_mux_op, stall_op, stall_count_op
    );

endinterface

// File: rtl/forward_controller_fwd_match.sv
// fwd_match: does a shadow entry produce the register this source operand reads
module fwd_match
    import forward_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  fwd_shadow_t           entry,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    output logic                  hit
);

    // x0 is hardwired zero, so it never counts as a producer
    assign hit = entry.valid & entry.wen & (entry.rd != '0) & (entry.rd == rs) & used;

endmodule

// File: rtl/forward_controller.sv
// forward_controller: EX-stage forward mux codes and load-use stall from an EX/MEM shadow of destinations
// Optional stall cycle counter enabled by defining FORWARD_STALL_COUNT_EN.
module forward_controller
    import forward_controller_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 32
) (
    input logic            clock,
    input logic            reset,
    forward_controller_if.slave bus
);

    fwd_shadow_t     ex_q, mem_q, ex_d, id_entry;
    forward_mux_code fa_q, fb_q, fa_d, fb_d;
    logic            hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, stall;
    logic            mem_load_unused;

    assign id_entry = '{valid: 1'b1, wen: bus.id_reg_write_ip, rd: bus.id_rd_addr_ip, load: bus.id_is_load_ip};
    assign mem_load_unused = mem_q.load;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_a  (.entry(ex_q),  .rs(bus.id_rs1_addr_ip), .used(bus.id_rs1_used_ip), .hit(hit_ex_a));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_b  (.entry(ex_q),  .rs(bus.id_rs2_addr_ip), .used(bus.id_rs2_used_ip), .hit(hit_ex_b));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_a (.entry(mem_q), .rs(bus.id_rs1_addr_ip), .used(bus.id_rs1_used_ip), .hit(hit_mem_a));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_b (.entry(mem_q), .rs(bus.id_rs2_addr_ip), .used(bus.id_rs2_used_ip), .hit(hit_mem_b));

    // A load result is not ready until MEM, so a dependent in Decode must wait one cycle; flush overrides
    assign stall = bus.id_valid_ip & ~bus.flush_en_ip & ex_q.load & (hit_ex_a | hit_ex_b);

    // Next EX entry and codes: flush or stall inject a bubble, otherwise youngest producer wins
    always_comb begin
        ex_d = FWD_BUBBLE;
        fa_d = FWD_NONE;
        fb_d = FWD_NONE;
        if (!bus.flush_en_ip && !stall) begin
            ex_d = bus.id_valid_ip ? id_entry : FWD_BUBBLE;
            fa_d = hit_ex_a ? FWD_MEM : (hit_mem_a ? FWD_WB : FWD_NONE);
            fb_d = hit_ex_b ? FWD_MEM : (hit_mem_b ? FWD_WB : FWD_NONE);
        end
    end

    // Shadow pipeline advance and registered codes aligned with the ID/EX buffer
    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_q  <= FWD_BUBBLE;
            mem_q <= FWD_BUBBLE;
            fa_q  <= FWD_NONE;
            fb_q  <= FWD_NONE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            fa_q  <= fa_d;
            fb_q  <= fb_d;
        end
    end

    assign bus.fa_mux_op = fa_q;
    assign bus.fb_mux_op = fb_q;
    assign bus.stall_op  = stall;

`ifdef FORWARD_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clock) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != {STALL_CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.stall_count_op = stall_cnt_q;
`else
    assign bus.stall_count_op = {STALL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_forward_controller.sv
// tb_forward_controller: directed forwarding/stall vectors with hand-computed expectations
module tb_forward_controller;
    import forward_controller_pkg::*;

`ifdef FORWARD_STALL_COUNT_EN
    localparam logic [31:0] CNT1 = 32'd1;
`else
    localparam logic [31:0] CNT1 = 32'd0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    forward_controller_if #(.REG_ADDR_W(5), .STALL_CNT_W(32)) bus ();

    forward_controller #(.REG_ADDR_W(5), .STALL_CNT_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        bus.id_valid_ip     = v;
        bus.id_rs1_addr_ip  = r1;
        bus.id_rs1_used_ip  = u1;
        bus.id_rs2_addr_ip  = r2;
        bus.id_rs2_used_ip  = u2;
        bus.id_rd_addr_ip   = rd;
        bus.id_reg_write_ip = we;
        bus.id_is_load_ip   = ld;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.flush_en_ip = 1'b0;
        // reset held for two cycles while Decode already presents a producer/consumer
        drive(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1);
        tick();
        tick();
        chk("rst_fa", bus.fa_mux_op, FWD_NONE);
        chk("rst_fb", bus.fb_mux_op, FWD_NONE);
        chk("rst_cnt", bus.stall_count_op, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_nostall", bus.stall_op, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // add x5,x1,x2 ; sub x6,x5,x7
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        #1 chk("add_nostall", bus.stall_op, 1'b0);
        tick();
        chk("add_fa", bus.fa_mux_op, FWD_NONE);
        drive(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
        #1 chk("sub_nostall", bus.stall_op, 1'b0);
        tick();
        chk("sub_fa", bus.fa_mux_op, FWD_MEM);
        chk("sub_fb", bus.fb_mux_op, FWD_NONE);

        // add x5 ; nop ; or x8,x9,x5
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 5'd9, 1, 5'd5, 1, 5'd8, 1, 0);
        tick();
        chk("or_fa", bus.fa_mux_op, FWD_NONE);
        chk("or_fb", bus.fb_mux_op, FWD_WB);

        // lw x5 ; add x6,x5,x5 : one stall cycle then WB forwarding
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        chk("lw_fa", bus.fa_mux_op, FWD_NONE);
        drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        #1 chk("lu_stall", bus.stall_op, 1'b1);
        tick();
        chk("lu_bub_fa", bus.fa_mux_op, FWD_NONE);
        chk("lu_bub_fb", bus.fb_mux_op, FWD_NONE);
        chk("lu_stall_end", bus.stall_op, 1'b0);
        chk("lu_cnt", bus.stall_count_op, CNT1);
        tick();
        chk("lu_fa", bus.fa_mux_op, FWD_WB);
        chk("lu_fb", bus.fb_mux_op, FWD_WB);

        // add x0 ; lw x0 ; add x7,x0,x0 : x0 never forwards or stalls
        drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        tick();
        drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
        tick();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0);
        #1 chk("x0_nostall", bus.stall_op, 1'b0);
        tick();
        chk("x0_fa", bus.fa_mux_op, FWD_NONE);
        chk("x0_fb", bus.fb_mux_op, FWD_NONE);

        // add x5 ; add x5 ; sub x?,x5,x5 : youngest producer wins
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 1, 5'd5, 1, 5'd11, 1, 0);
        tick();
        chk("yng_fa", bus.fa_mux_op, FWD_MEM);
        chk("yng_fb", bus.fb_mux_op, FWD_MEM);

        // lw x9 ; add x10,x1,x2 : independent, no stall
        drive(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1);
        tick();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0);
        #1 chk("indep_nostall", bus.stall_op, 1'b0);
        tick();
        chk("indep_fa", bus.fa_mux_op, FWD_NONE);

        // lw x5 ; add x6,x5,x5 with flush : flush beats stall
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        bus.flush_en_ip = 1'b1;
        #1 chk("fl_nostall", bus.stall_op, 1'b0);
        tick();
        bus.flush_en_ip = 1'b0;
        chk("fl_fa", bus.fa_mux_op, FWD_NONE);
        chk("fl_fb", bus.fb_mux_op, FWD_NONE);
        #1 chk("fl_ex_bubble", bus.stall_op, 1'b0);
        chk("fl_cnt", bus.stall_count_op, CNT1);

        // lw x5 ; dependent add ; reset asserted during the stall cycle
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        #1 chk("rs_stall", bus.stall_op, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 chk("rs_nostall", bus.stall_op, 1'b0);
        chk("rs_cnt", bus.stall_count_op, 32'd0);
        tick();
        chk("rs_fa", bus.fa_mux_op, FWD_NONE);
        chk("rs_fb", bus.fb_mux_op, FWD_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
